light_collider: RTL and testbench
=================================

# light_collider

Per-frame collision detector between the player box and the two light streaks. It consumes the same 12-bit edge-coordinate buses the animation blocks produce and the scan position from the VGA timing block. It counts overlapping pixels during active scan and posts one collision event per frame through a valid/ack handshake to game control.

## Interface
- D_WIDTH, 640, active display width
- D_HEIGHT, 480, active display height
- HIT_THRESH, 16, minimum overlap pixels for one light to count as a collision
- CW, 20, overlap counter width (saturating)

- i_clk  in  1  base clock
- i_rst  in  1  reset: synchronous, active-high
- i_pix_stb  in  1  pixel strobe; scan inputs valid only when high
- i_x, i_y  in  12 each  current scan position
- i_animate  in  1  end-of-active-frame marker, qualified by i_pix_stb
- i_paused  in  1  high suppresses counting and event posting
- i_px1, i_px2, i_py1, i_py2  in  12 each  player box edges (left, right, top, bottom)
- i_1x1, i_1x2, i_1y1, i_1y2  in  12 each  light 1 edges
- i_2x1, i_2x2, i_2y1, i_2y2  in  12 each  light 2 edges
- o_hit_pix  out  1  registered: current pixel is inside the player box and inside either light
- o_coll_valid  out  1  collision event pending
- i_coll_ack  in  1  consumer accepts the event
- o_coll_src  out  2  bit0 = light 1 over threshold, bit1 = light 2 over threshold
- o_coll_count  out  CW  saturated sum of both overlap counts
- o_overrun  out  1  sticky: a later event was dropped while one was pending

## Operation
- Frame start is i_pix_stb && i_x==0 && i_y==0.
  - Latch all 12 edge inputs into shadow registers.
  - Clear both counters.
  - FSM goes IDLE→SCAN, or SCAN→SCAN.
- Containment uses exclusive bounds: x1 < x < x2 and y1 < y < y2, unsigned 12-bit. A rect with x1 >= x2 or y1 >= y2, including an edge that underflowed, is empty.
- Stage 1, on each i_pix_stb in SCAN: register inP, in1, in2 from the shadow edges.
  - o_hit_pix = inP & (in1 | in2).
- Stage 2, when the stage-1 strobe is delayed by one cycle and i_paused is low: cnt1 += inP & in1 and cnt2 += inP & in2, each saturating at 2^CW−1.
- i_animate && i_pix_stb in SCAN moves the FSM to REPORT for exactly one cycle, so the last pixel can land. In REPORT:
  - src = {cnt2>=HIT_THRESH, cnt1>=HIT_THRESH}. If src is nonzero and i_paused is low, an event fires.
  - Event with no event pending: load o_coll_src, o_coll_count = sat(cnt1+cnt2), and set o_coll_valid.
  - Event while one is pending with no ack this cycle: keep the held values and set o_overrun.
  - Event in the same cycle as an ack: load the new event, o_coll_valid stays 1, no overrun.
- REPORT→SCAN.
- Ack: i_coll_ack && o_coll_valid clears o_coll_valid and o_overrun on the next edge. Ack while valid is low is ignored.
- Outputs hold stable while o_coll_valid is high.
- FSM states:
  - IDLE: after reset; no counting, o_hit_pix=0.
  - SCAN
  - REPORT
- Reset mid-frame: every register goes to 0 and the FSM to IDLE. Shadow rects read as empty until the next frame start, and the partial frame is never reported.

## Timing
- Reset values: o_hit_pix=0, o_coll_valid=0, o_coll_src=0, o_coll_count=0, o_overrun=0, FSM=IDLE.
- o_hit_pix: 1 clock after the strobe, held until the next strobe.
- Event: o_coll_valid rises 2 clocks after the i_animate strobe (strobe → REPORT → registered valid).
- Ack: o_coll_valid falls 1 clock after the ack edge.
- Edge-input changes mid-frame have no effect until the next frame start.

## Structure
- Shared package `game_pkg`:
  - coordinate width constant (12)
  - FSM enum {IDLE, SCAN, REPORT}
  - rect struct {x1, x2, y1, y2}
- One sub-module, `rect_hit`: combinational point-in-rect test with exclusive bounds and the empty-rect rule. Instantiated three times.

## Test plan
- Overlap count and event:
  - Stimulus: player (300,340,400,440), light 1 (240,400,0,480), light 2 empty (0,0,0,0), full 640×480 frame.
  - Response: cnt1 = 39×39 = 1521; o_coll_valid rises 2 clocks after i_animate; src=01; count=1521.
- Below threshold:
  - Stimulus: player (300,305,400,405), light 1 as above (16 overlap pixels). Then the same with HIT_THRESH=17.
  - Response: event with count=16; no event at HIT_THRESH=17.
- Pending event and ack:
  - Stimulus: event pending, no ack, a second colliding frame.
  - Response: held values unchanged; o_overrun=1.
  - Stimulus: ack.
  - Response: valid and overrun both 0 next cycle.
- Ack coincides with REPORT of a new event:
  - Response: valid stays 1; new src/count loaded; o_overrun=0.
- Empty rect, pause and mid-frame changes:
  - Light 1 with x1=4090, x2=70: zero count.
  - i_paused high for a whole frame: no event.
  - Edge inputs changed mid-frame: count uses the frame-start values.
- Reset mid-frame:
  - Stimulus: i_rst at y=200, then a colliding frame.
  - Response: all outputs 0; no event for the partial frame; the next full frame reports normally.

Source files
------------

// File: rtl/game_pkg.sv
// Shared game types: coordinate width, collider FSM states and the edge
// rectangle carried on the animation buses.
package game_pkg;

    localparam int COORD_W = 12;

    typedef logic [COORD_W-1:0] coord_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        REPORT = 2'd2
    } state_e;

    typedef struct packed {
        coord_t x1;
        coord_t x2;
        coord_t y1;
        coord_t y2;
    } rect_t;

endpackage

// File: rtl/light_collider_if.sv
// Collision event channel from the collider to game control.
interface light_collider_if #(
    parameter int CW = 20
);
    // Handshake: coll_valid holds an event (src/count/overrun stable) until
    // the cycle coll_ack is sampled high with coll_valid high; ack while
    // coll_valid is low has no effect.
    logic          coll_valid;
    logic          coll_ack;
    logic [1:0]    coll_src;
    logic [CW-1:0] coll_count;
    logic          overrun;

    modport master (
        output coll_valid,
        output coll_src,
        output coll_count,
        output overrun,
        input  coll_ack
    );

    modport slave (
        input  coll_valid,
        input  coll_src,
        input  coll_count,
        input  overrun,
        output coll_ack
    );

endinterface

// File: rtl/light_collider_rect_hit.sv
// Point-in-rectangle test with exclusive bounds; a rect with x1>=x2 or
// y1>=y2 contains no point, which the strict compares give for free.
module rect_hit
    import game_pkg::*;
(
    input  coord_t x_i,
    input  coord_t y_i,
    input  rect_t  r_i,
    output logic   hit_o
);

    assign hit_o = (r_i.x1 < x_i) && (x_i < r_i.x2) &&
                   (r_i.y1 < y_i) && (y_i < r_i.y2);

endmodule

// File: rtl/light_collider.sv
// Per-frame player/light overlap counter posting one collision event per
// frame on a valid/ack channel.
module light_collider
    import game_pkg::*;
#(
    parameter int D_WIDTH    = 640,
    parameter int D_HEIGHT   = 480,
    parameter int HIT_THRESH = 16,
    parameter int CW         = 20
) (
    input  logic   i_clk,
    input  logic   i_rst,
    input  logic   i_pix_stb,
    input  coord_t i_x,
    input  coord_t i_y,
    input  logic   i_animate,
    input  logic   i_paused,
    input  coord_t i_px1,
    input  coord_t i_px2,
    input  coord_t i_py1,
    input  coord_t i_py2,
    input  coord_t i_1x1,
    input  coord_t i_1x2,
    input  coord_t i_1y1,
    input  coord_t i_1y2,
    input  coord_t i_2x1,
    input  coord_t i_2x2,
    input  coord_t i_2y1,
    input  coord_t i_2y2,
    output logic   o_hit_pix,
    output state_e o_state,
    light_collider_if.master coll
);

    localparam coord_t        ACT_W   = coord_t'(D_WIDTH);
    localparam coord_t        ACT_H   = coord_t'(D_HEIGHT);
    localparam logic [CW-1:0] THRESH  = CW'(HIT_THRESH);
    localparam logic [CW-1:0] CNT_MAX = '1;

    state_e state_q, state_d;
    rect_t  sh_p_q, sh_1_q, sh_2_q;
    logic   hit_p, hit_1, hit_2;
    logic   stb1_q, inp_q, in1_q, in2_q, hit_q;
    logic [CW-1:0] cnt1_q, cnt1_d, cnt2_q, cnt2_d;
    logic [CW:0]   sum;
    logic [CW-1:0] sum_sat;
    logic [1:0]    src;
    logic          valid_q, valid_d, ovr_q, ovr_d;
    logic [1:0]    src_q, src_d;
    logic [CW-1:0] count_q, count_d;

    wire frame_start = i_pix_stb && (i_x == '0) && (i_y == '0);
    wire anim_stb    = i_pix_stb && i_animate;
    wire scan_active = (state_q == SCAN) && (i_x < ACT_W) && (i_y < ACT_H);

    rect_hit u_hit_p (.x_i(i_x), .y_i(i_y), .r_i(sh_p_q), .hit_o(hit_p));
    rect_hit u_hit_1 (.x_i(i_x), .y_i(i_y), .r_i(sh_1_q), .hit_o(hit_1));
    rect_hit u_hit_2 (.x_i(i_x), .y_i(i_y), .r_i(sh_2_q), .hit_o(hit_2));

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (frame_start) state_d = SCAN;
            SCAN:    if (!frame_start && anim_stb) state_d = REPORT;
            REPORT:  state_d = SCAN;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            sh_p_q  <= '0;
            sh_1_q  <= '0;
            sh_2_q  <= '0;
        end else begin
            state_q <= state_d;
            if (frame_start) begin
                sh_p_q <= '{x1: i_px1, x2: i_px2, y1: i_py1, y2: i_py2};
                sh_1_q <= '{x1: i_1x1, x2: i_1x2, y1: i_1y1, y2: i_1y2};
                sh_2_q <= '{x1: i_2x1, x2: i_2x2, y1: i_2y1, y2: i_2y2};
            end
        end
    end

    // Stage 1: containment flags, held between strobes.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            stb1_q <= 1'b0;
            inp_q  <= 1'b0;
            in1_q  <= 1'b0;
            in2_q  <= 1'b0;
            hit_q  <= 1'b0;
        end else begin
            stb1_q <= i_pix_stb && scan_active;
            if (i_pix_stb) begin
                inp_q <= scan_active && hit_p;
                in1_q <= scan_active && hit_1;
                in2_q <= scan_active && hit_2;
                hit_q <= scan_active && hit_p && (hit_1 || hit_2);
            end
        end
    end

    // Stage 2: saturating overlap counters; REPORT reads the next-state value
    // so the pixel strobed together with i_animate is included.
    always_comb begin
        cnt1_d = cnt1_q;
        cnt2_d = cnt2_q;
        if (frame_start) begin
            cnt1_d = '0;
            cnt2_d = '0;
        end else if (stb1_q && !i_paused) begin
            if (inp_q && in1_q && cnt1_q != CNT_MAX) cnt1_d = cnt1_q + 1'b1;
            if (inp_q && in2_q && cnt2_q != CNT_MAX) cnt2_d = cnt2_q + 1'b1;
        end
        sum     = {1'b0, cnt1_d} + {1'b0, cnt2_d};
        sum_sat = sum[CW] ? CNT_MAX : sum[CW-1:0];
        src     = {cnt2_d >= THRESH, cnt1_d >= THRESH};
    end

    always_comb begin
        valid_d = valid_q;
        ovr_d   = ovr_q;
        src_d   = src_q;
        count_d = count_q;
        if (state_q == REPORT && !i_paused && src != 2'b00) begin
            if (!valid_q || coll.coll_ack) begin
                valid_d = 1'b1;
                ovr_d   = 1'b0;
                src_d   = src;
                count_d = sum_sat;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (coll.coll_ack && valid_q) begin
            valid_d = 1'b0;
            ovr_d   = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt1_q  <= '0;
            cnt2_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
            src_q   <= '0;
            count_q <= '0;
        end else begin
            cnt1_q  <= cnt1_d;
            cnt2_q  <= cnt2_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
            src_q   <= src_d;
            count_q <= count_d;
        end
    end

    assign o_hit_pix       = hit_q;
    assign o_state         = state_q;
    assign coll.coll_valid = valid_q;
    assign coll.coll_src   = src_q;
    assign coll.coll_count = count_q;
    assign coll.overrun    = ovr_q;

endmodule

// File: tb/tb_light_collider.sv
// Bench for light_collider: pixel-hit vector table, directed event frames,
// randomized frames against an interval-arithmetic overlap model.
module tb_light_collider;
    import game_pkg::*;

    localparam int CW     = 20;
    localparam int THRESH = 16;

    logic   clk = 1'b0;
    logic   rst;
    logic   stb, animate, paused;
    coord_t x, y;
    rect_t  rp, r1, r2;
    logic   hit_a, hit_b;
    state_e st_a, st_b;

    light_collider_if #(.CW(CW)) cif ();
    light_collider_if #(.CW(CW)) cif17 ();

    always #5 clk = ~clk;

    light_collider #(.HIT_THRESH(THRESH), .CW(CW)) dut (
        .i_clk(clk), .i_rst(rst), .i_pix_stb(stb), .i_x(x), .i_y(y),
        .i_animate(animate), .i_paused(paused),
        .i_px1(rp.x1), .i_px2(rp.x2), .i_py1(rp.y1), .i_py2(rp.y2),
        .i_1x1(r1.x1), .i_1x2(r1.x2), .i_1y1(r1.y1), .i_1y2(r1.y2),
        .i_2x1(r2.x1), .i_2x2(r2.x2), .i_2y1(r2.y1), .i_2y2(r2.y2),
        .o_hit_pix(hit_a), .o_state(st_a), .coll(cif.master)
    );

    light_collider #(.HIT_THRESH(17), .CW(CW)) dut17 (
        .i_clk(clk), .i_rst(rst), .i_pix_stb(stb), .i_x(x), .i_y(y),
        .i_animate(animate), .i_paused(paused),
        .i_px1(rp.x1), .i_px2(rp.x2), .i_py1(rp.y1), .i_py2(rp.y2),
        .i_1x1(r1.x1), .i_1x2(r1.x2), .i_1y1(r1.y1), .i_1y2(r1.y2),
        .i_2x1(r2.x1), .i_2x2(r2.x2), .i_2y1(r2.y1), .i_2y2(r2.y2),
        .o_hit_pix(hit_b), .o_state(st_b), .coll(cif17.master)
    );

    int total = 0;
    int bad   = 0;

    // Reference state for the threshold-16 device.
    logic          exp_v, exp_ov;
    logic [CW+1:0] exp_q[$];

    typedef struct {
        int   vx;
        int   vy;
        logic exp_hit;
    } vec_t;
    vec_t tbl[9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic rect_t mk(input int a, input int b, input int c, input int d);
        rect_t r;
        r.x1 = coord_t'(a); r.x2 = coord_t'(b); r.y1 = coord_t'(c); r.y2 = coord_t'(d);
        return r;
    endfunction

    function automatic rect_t rnd_rect();
        rect_t r;
        r.x1 = ($urandom_range(0, 7) == 0) ? 12'd4090 : coord_t'($urandom_range(0, 40));
        r.x2 = coord_t'($urandom_range(0, 40));
        r.y1 = coord_t'($urandom_range(0, 40));
        r.y2 = coord_t'($urandom_range(0, 40));
        return r;
    endfunction

    // Integer points of the open interval intersection clipped to [w0,w1].
    function automatic int span(input int a1, input int a2, input int b1, input int b2,
                                input int w0, input int w1);
        int lo, hi;
        lo = ((a1 > b1) ? a1 : b1) + 1;
        hi = ((a2 < b2) ? a2 : b2) - 1;
        if (lo < w0) lo = w0;
        if (hi > w1) hi = w1;
        return (hi >= lo) ? (hi - lo + 1) : 0;
    endfunction

    function automatic int overlap(input rect_t p, input rect_t l,
                                   input int wx0, input int wx1, input int wy0, input int wy1);
        return span(int'(p.x1), int'(p.x2), int'(l.x1), int'(l.x2), wx0, wx1) *
               span(int'(p.y1), int'(p.y2), int'(l.y1), int'(l.y2), wy0, wy1);
    endfunction

    function automatic logic [CW-1:0] sat(input int s);
        return (s > (2 ** CW) - 1) ? {CW{1'b1}} : CW'(s);
    endfunction

    task automatic model_report(input int c1, input int c2, input bit pz, input bit ack);
        logic [1:0] s;
        s = {c2 >= THRESH, c1 >= THRESH};
        if (!pz && s != 2'b00) begin
            if (!exp_v || ack) begin
                exp_q.push_back({s, sat(c1 + c2)});
                exp_v  = 1'b1;
                exp_ov = 1'b0;
            end else begin
                exp_ov = 1'b1;
            end
        end else if (ack && exp_v) begin
            exp_v  = 1'b0;
            exp_ov = 1'b0;
        end
    endtask

    task automatic check_outputs(input string tag);
        logic [CW+1:0] e;
        e = (exp_q.size() > 0) ? exp_q[$] : '0;
        check({tag, "_valid"}, cif.coll_valid, exp_v);
        check({tag, "_src"}, cif.coll_src, e[CW+1:CW]);
        check({tag, "_count"}, cif.coll_count, e[CW-1:0]);
        check({tag, "_overrun"}, cif.overrun, exp_ov);
    endtask

    task automatic pix(input int px, input int py, input bit anim);
        @(negedge clk);
        stb = 1'b1; x = coord_t'(px); y = coord_t'(py); animate = anim;
        cif.coll_ack = 1'b0; cif17.coll_ack = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic idle_cyc(input bit ack);
        @(negedge clk);
        stb = 1'b0; animate = 1'b0;
        cif.coll_ack = ack; cif17.coll_ack = ack;
        @(posedge clk); #1;
    endtask

    task automatic do_ack(input string tag);
        idle_cyc(1'b1);
        if (exp_v) begin
            exp_v  = 1'b0;
            exp_ov = 1'b0;
        end
        check({tag, "_ack_valid"}, cif.coll_valid, exp_v);
        check({tag, "_ack_overrun"}, cif.overrun, exp_ov);
        idle_cyc(1'b0);
    endtask

    // One frame: start pixel, a scan window, then the animate strobe.
    task automatic run_frame(input string tag, input rect_t p, input rect_t l1, input rect_t l2,
                             input int wx0, input int wx1, input int wy0, input int wy1,
                             input bit pz, input bit garble, input bit ack_rep);
        int c1, c2;
        rp = p; r1 = l1; r2 = l2; paused = pz;
        pix(0, 0, 1'b0);
        if (garble) begin
            rp = rnd_rect(); r1 = rnd_rect(); r2 = rnd_rect();
        end
        for (int yy = wy0; yy <= wy1; yy++)
            for (int xx = wx0; xx <= wx1; xx++)
                if (!(xx == 0 && yy == 0)) pix(xx, yy, 1'b0);
        pix(0, 480, 1'b1);
        check({tag, "_valid_pre"}, cif.coll_valid, exp_v);
        c1 = pz ? 0 : overlap(p, l1, wx0, wx1, wy0, wy1);
        c2 = pz ? 0 : overlap(p, l2, wx0, wx1, wy0, wy1);
        model_report(c1, c2, pz, ack_rep);
        idle_cyc(ack_rep);
        paused = 1'b0;
        check_outputs(tag);
    endtask

    initial begin
        rect_t pbig, psmall, lA, lnone, lwrap, pres;
        rst = 1'b1; stb = 1'b0; animate = 1'b0; paused = 1'b0;
        x = '0; y = '0; rp = '0; r1 = '0; r2 = '0;
        cif.coll_ack = 1'b0; cif17.coll_ack = 1'b0;
        exp_v = 1'b0; exp_ov = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check_outputs("reset");
        check("reset_hit", hit_a, 1'b0);
        check("reset_state", st_a, IDLE);
        @(negedge clk); rst = 1'b0;

        // Pixel-hit table.
        rp = mk(300, 340, 400, 440); r1 = mk(240, 320, 0, 480); r2 = mk(330, 500, 430, 500);
        tbl[0] = '{301, 401, 1'b1};
        tbl[1] = '{300, 401, 1'b0};
        tbl[2] = '{319, 439, 1'b1};
        tbl[3] = '{320, 420, 1'b0};
        tbl[4] = '{331, 431, 1'b1};
        tbl[5] = '{339, 440, 1'b0};
        tbl[6] = '{325, 425, 1'b0};
        tbl[7] = '{500, 450, 1'b0};
        tbl[8] = '{339, 439, 1'b1};
        pix(301, 401, 1'b0);
        check("idle_hit", hit_a, 1'b0);
        pix(0, 0, 1'b0);
        check("start_hit", hit_a, 1'b0);
        check("scan_state", st_a, SCAN);
        for (int i = 0; i < 9; i++) begin
            pix(tbl[i].vx, tbl[i].vy, 1'b0);
            check($sformatf("tbl%0d_hit", i), hit_a, tbl[i].exp_hit);
        end
        idle_cyc(1'b0); idle_cyc(1'b0);
        check("hit_hold", hit_a, 1'b1);

        pbig   = mk(300, 340, 400, 440);
        psmall = mk(300, 305, 400, 405);
        lA     = mk(240, 400, 0, 480);
        lnone  = mk(0, 0, 0, 0);
        lwrap  = mk(4090, 70, 0, 480);

        run_frame("big", pbig, lA, lnone, 296, 344, 396, 444, 1'b0, 1'b0, 1'b0);
        run_frame("overrun", psmall, lA, lnone, 296, 310, 396, 410, 1'b0, 1'b0, 1'b0);
        do_ack("first");
        run_frame("thresh16", psmall, lA, lnone, 296, 310, 396, 410, 1'b0, 1'b0, 1'b0);
        check("thresh17_valid", cif17.coll_valid, 1'b0);
        check("thresh17_overrun", cif17.overrun, 1'b0);
        run_frame("ack_in_report", pbig, lA, lnone, 296, 344, 396, 444, 1'b0, 1'b0, 1'b1);
        do_ack("second");
        run_frame("wrap_empty", mk(5, 60, 5, 60), lwrap, lnone, 0, 64, 0, 64, 1'b0, 1'b0, 1'b0);
        run_frame("paused", pbig, lA, lnone, 296, 344, 396, 444, 1'b1, 1'b0, 1'b0);
        run_frame("midframe", pbig, lA, lnone, 296, 344, 396, 444, 1'b0, 1'b1, 1'b0);

        for (int i = 0; i < 8; i++) begin
            if ($urandom_range(0, 2) == 0) do_ack($sformatf("rnd%0d", i));
            run_frame($sformatf("rnd%0d", i), rnd_rect(), rnd_rect(), rnd_rect(), 0, 39, 0, 39,
                      ($urandom_range(0, 5) == 0), ($urandom_range(0, 1) == 1),
                      ($urandom_range(0, 3) == 0));
        end

        // Reset in the middle of a colliding frame.
        pres = mk(300, 340, 180, 220);
        run_frame("pre_reset", pres, lA, lnone, 296, 344, 176, 224, 1'b0, 1'b0, 1'b0);
        pix(0, 0, 1'b0);
        for (int yy = 176; yy <= 200; yy++)
            for (int xx = 296; xx <= 344; xx++) pix(xx, yy, 1'b0);
        @(negedge clk); rst = 1'b1; stb = 1'b0;
        @(posedge clk); #1;
        exp_v = 1'b0; exp_ov = 1'b0; exp_q.delete();
        check_outputs("midreset");
        check("midreset_hit", hit_a, 1'b0);
        check("midreset_state", st_a, IDLE);
        @(negedge clk); rst = 1'b0;
        for (int yy = 201; yy <= 224; yy++)
            for (int xx = 296; xx <= 344; xx++) pix(xx, yy, 1'b0);
        pix(0, 480, 1'b1);
        idle_cyc(1'b0); idle_cyc(1'b0);
        check_outputs("partial");
        check("partial_state", st_a, IDLE);
        run_frame("post_reset", pres, lA, lnone, 296, 344, 176, 224, 1'b0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
